// File: rtl/dma_lite_arbiter.sv
// dma_lite_arbiter: round-robin share of one AXI4-Lite write port between the MM2S and S2MM register requesters.
module dma_lite_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_awaddr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_awaddr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [ADDR_W-1:0] m_axi_lite_awaddr,
  output logic              m_axi_lite_awvalid,
  input  logic              m_axi_lite_awready,
  output logic [DATA_W-1:0] m_axi_lite_wdata,
  output logic              m_axi_lite_wvalid,
  input  logic              m_axi_lite_wready,
  input  logic [1:0]        m_axi_lite_bresp,
  input  logic              m_axi_lite_bvalid,
  output logic              m_axi_lite_bready,
  output logic              busy,
  output logic              grant
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic grant_q, grant_d, busy_q, busy_d;
  logic done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
  logic sel, fin, fin_err, tmo, aw_hs, w_hs, b_hs;
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    sel       = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
    aw_hs     = awvalid_q & m_axi_lite_awready;
    w_hs      = wvalid_q & m_axi_lite_wready;
    b_hs      = bready_q & m_axi_lite_bvalid;
    tmo       = cnt_q == CW'(TIMEOUT_CYC - 1);
    fin       = 1'b0;
    fin_err   = 1'b1;
    unique case (state_q)
      IDLE: if (req0_valid || req1_valid) begin
        grant_d   = sel;
        awaddr_d  = sel ? req1_awaddr : req0_awaddr;
        wdata_d   = sel ? req1_wdata : req0_wdata;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        cnt_d     = '0;
        state_d   = ADDR_DATA;
      end
      ADDR_DATA: begin
        cnt_d     = cnt_q + CW'(1);
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        awvalid_d = awvalid_q & ~aw_hs;
        wvalid_d  = wvalid_q & ~w_hs;
        fin       = tmo;
        if (!tmo && aw_done_d && w_done_d) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        cnt_d   = cnt_q + CW'(1);
        fin     = b_hs | tmo;
        fin_err = b_hs ? (m_axi_lite_bresp != 2'b00) : 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Completion (B response or timeout abort) drops every valid at once.
    if (fin) begin
      state_d   = DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
    end
    done0_d = fin & ~grant_q;
    done1_d = fin & grant_q;
    err0_d  = fin & ~grant_q & fin_err;
    err1_d  = fin & grant_q & fin_err;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      grant_q   <= 1'b1;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end
  assign m_axi_lite_awaddr  = awaddr_q;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign req0_done = done0_q;
  assign req0_err  = err0_q;
  assign req1_done = done1_q;
  assign req1_err  = err1_q;
endmodule

// File: doc/dma_lite_arbiter.md
Name: dma_lite_arbiter

Overview:
- Shares the single AXI4-Lite master write port of the DMA register interface between two register-programming requesters: requester 0 is the MM2S channel controller and requester 1 is the S2MM channel controller.
- Each requester presents one register write (address and data). The block grants requesters round-robin, runs the full AW/W/B handshake and returns a one-cycle done pulse with an error flag.
- It sits between the channel controllers and the m_axi_lite write channels of the DMA core.

Parameters:
- ADDR_W, 10, AXI-Lite address width.
- DATA_W, 32, AXI-Lite data width.
- TIMEOUT_CYC, 1024, cycles allowed from grant to B handshake before the transaction is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 write request (level, held until req0_done)
- req0_awaddr  in  ADDR_W  requester 0 register address
- req0_wdata  in  DATA_W  requester 0 write data
- req0_done  out  1  one-cycle completion pulse for requester 0
- req0_err  out  1  error qualifier for requester 0, valid only with req0_done
- req1_valid, req1_awaddr, req1_wdata, req1_done, req1_err  same as requester 0, for requester 1
- m_axi_lite_awaddr  out  ADDR_W  write address
- m_axi_lite_awvalid  out  1  address valid
- m_axi_lite_awready  in  1  address ready
- m_axi_lite_wdata  out  DATA_W  write data
- m_axi_lite_wvalid  out  1  data valid
- m_axi_lite_wready  in  1  data ready
- m_axi_lite_bresp  in  2  write response
- m_axi_lite_bvalid  in  1  response valid
- m_axi_lite_bready  out  1  response ready
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the current or last granted requester

Behaviour:
- Reset values:
  - state = IDLE.
  - awvalid, wvalid, bready, busy, req*_done, req*_err = 0.
  - awaddr and wdata = 0; grant = 1; last_grant = 1, so requester 0 wins the first simultaneous request.
  - Timeout counter = 0.
  - Reset mid-transaction forces all of the above on the next edge. No done pulse is issued for the aborted transfer.
- All outputs are registered.
- FSM state IDLE:
  - One valid asserted: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - On grant: latch that requester's awaddr/wdata into the output registers, set grant and last_grant, set awvalid = wvalid = 1, clear the timeout counter, go to ADDR_DATA.
  - Neither valid: stay in IDLE.
- FSM state ADDR_DATA:
  - awvalid clears on the cycle after awvalid && awready.
  - wvalid clears on the cycle after wvalid && wready.
  - The AW and W handshakes are independent and may occur in the same cycle or in either order.
  - When both handshakes are complete (tracked by aw_done/w_done flags), go to RESP with bready = 1.
  - awaddr and wdata remain stable while their valid is high.
- FSM state RESP:
  - On bvalid && bready: bready = 0, err = (bresp != 2'b00), go to DONE.
- FSM state DONE:
  - One cycle. req[grant]_done = 1 and req[grant]_err = err. The other requester's done/err stay 0.
  - Next state IDLE. A requester sampled in IDLE must already have deasserted valid; a registered requester that drops valid the cycle after seeing done satisfies this.
- Timeout:
  - The counter increments every cycle in ADDR_DATA or RESP.
  - When it reaches TIMEOUT_CYC-1 without the B handshake: drop awvalid, wvalid and bready, set err = 1, go to DONE.
  - This recovery deliberately violates AXI valid-stability and is for fault recovery only.
- Minimum latency (single request, awready = wready = 1, bvalid immediate):
  - req seen at cycle 0.
  - awvalid/wvalid high at cycle 1.
  - bready high at cycle 2, B handshake at cycle 2.
  - done at cycle 3.
  - IDLE at cycle 4, so the next grant can be observed at cycle 5.
- A request arriving while busy waits. Requests are never dropped; valid stays high until that requester's done.
- No overlap: at most one outstanding AXI-Lite write.

Test Plan:
- Single request: req0 addr 0x018, data 0x1000_0000, slave always ready, bresp 0 -> awvalid at cycle 1 with awaddr 0x018 and wdata 0x1000_0000; req0_done at cycle 3 with err 0; req1_done stays 0.
- Simultaneous req0/req1 held after reset -> grant order 0, 1, 0, 1 across four consecutive transactions; each done pulse routed only to the granted requester.
- Skewed handshake: awready high at cycle 1, wready delayed to cycle 5 -> awvalid low from cycle 2; wvalid held with stable wdata until cycle 5; bready rises at cycle 6.
- Error response: bresp 2'b10 on the B handshake -> req1_done = 1 with req1_err = 1, then IDLE.
- Timeout: awready held at 0 with TIMEOUT_CYC = 16 -> awvalid/wvalid drop and req0_done with err = 1 exactly 16 cycles after grant; the next request is served normally.
- Reset asserted in RESP -> the next cycle shows all outputs at reset values and no done pulse; after reset, a simultaneous request grants requester 0.
